// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Resolves control-flow instructions leaving fetch. Conditional
//            branches (BEQ/BNE/BLTZ) wait for their operands, are evaluated,
//            and, when taken, produce a one-cycle redirect pulse followed by
//            a programmable flush window. JAL redirects unconditionally on
//            the cycle after acceptance. Keeps saturating branch statistics
//            and a sticky operand-timeout error.
// Ports    : clk, reset               - clock / synchronous active-high reset
//            instr_valid, instr,      - instruction from fetch (decoded only
//            instr_pc                   while idle; pc is debug-only)
//            operand_valid, rs1_data, - branch operands from register read
//            rs2_data
//            beq, bneq, bltz, jump    - mutually exclusive redirect pulses
//            imm_address              - B-type offset, sign-extended to 16b
//            imm_address_jump         - J-type offset, sign-extended to 32b
//            flush, stall_fetch, busy - pipeline control / status
//            branch_count,taken_count - saturating statistics
//            error                    - sticky operand timeout
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES    = 2,
    parameter int OPERAND_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [31:0] instr_pc,
    input  logic        operand_valid,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        beq,
    output logic        bneq,
    output logic        bltz,
    output logic        jump,
    output logic [15:0] imm_address,
    output logic [31:0] imm_address_jump,
    output logic        flush,
    output logic        stall_fetch,
    output logic        busy,
    output logic [15:0] branch_count,
    output logic [15:0] taken_count,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_OPS = 2'd1,
        S_REDIRECT = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    localparam logic [6:0]  c_OP_BRANCH  = 7'b1100011;
    localparam logic [6:0]  c_OP_JAL     = 7'b1101111;
    localparam logic [2:0]  c_F3_BEQ     = 3'b000;
    localparam logic [2:0]  c_F3_BNE     = 3'b001;
    localparam logic [2:0]  c_F3_BLTZ    = 3'b100;
    localparam logic [3:0]  c_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0]  c_TMO_LAST   = 8'(OPERAND_TIMEOUT - 1);
    localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;
    localparam logic        c_HAS_FLUSH  = (FLUSH_CYCLES > 1);

    state_t      r_state;
    state_t      w_state_next;

    // One-hot {beq, bne, bltz} of the branch waiting for operands
    logic [2:0]  r_br_sel;
    logic [7:0]  r_tmo_cnt;
    logic [3:0]  r_flush_cnt;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [2:0]  w_dec_sel;
    logic        w_dec_br;
    logic        w_dec_jal;
    logic        w_accept;
    logic [15:0] w_b_off;
    logic [31:0] w_j_off;
    logic        w_taken;
    logic [3:0]  w_pulse_next;
    logic        w_branch_resolved;
    logic        w_timeout;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_opcode  = instr[6:0];
    assign w_funct3  = instr[14:12];
    assign w_dec_sel = {w_funct3 == c_F3_BEQ, w_funct3 == c_F3_BNE, w_funct3 == c_F3_BLTZ};
    assign w_dec_br  = instr_valid && (w_opcode == c_OP_BRANCH) && (|w_dec_sel);
    assign w_dec_jal = instr_valid && (w_opcode == c_OP_JAL);
    assign w_accept  = (r_state == S_IDLE) && (w_dec_br || w_dec_jal);

    assign w_b_off = {{3{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_j_off = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Condition of the pending branch; BLTZ looks only at the sign of rs1
    assign w_taken = |(r_br_sel & {rs1_data == rs2_data,
                                   rs1_data != rs2_data,
                                   rs1_data[31]});

    // ------------------------------------------------------------------
    // Next-state and redirect decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_pulse_next      = 4'b0000;
        w_branch_resolved = 1'b0;
        w_timeout         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_dec_jal) begin
                    w_state_next = S_REDIRECT;
                    w_pulse_next = 4'b0001;
                end else if (w_dec_br) begin
                    w_state_next = S_WAIT_OPS;
                end
            end
            S_WAIT_OPS: begin
                // Operands arriving on the last allowed cycle still win
                // over the timeout.
                if (operand_valid) begin
                    w_branch_resolved = 1'b1;
                    if (w_taken) begin
                        w_state_next = S_REDIRECT;
                        w_pulse_next = {r_br_sel, 1'b0};
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_REDIRECT: begin
                w_state_next = c_HAS_FLUSH ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                // r_flush_cnt counts flush cycles already spent, the
                // redirect cycle included.
                if (r_flush_cnt == c_FLUSH_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs. Outputs are computed from the next
    // state so they line up with the state they describe while remaining
    // flop outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_br_sel         <= 3'b000;
            r_tmo_cnt        <= 8'd0;
            r_flush_cnt      <= 4'd0;
            beq              <= 1'b0;
            bneq             <= 1'b0;
            bltz             <= 1'b0;
            jump             <= 1'b0;
            imm_address      <= 16'd0;
            imm_address_jump <= 32'd0;
            flush            <= 1'b0;
            stall_fetch      <= 1'b0;
            busy             <= 1'b0;
            branch_count     <= 16'd0;
            taken_count      <= 16'd0;
            error            <= 1'b0;
        end else begin
            r_state                 <= w_state_next;
            {beq, bneq, bltz, jump} <= w_pulse_next;
            flush       <= (w_state_next == S_REDIRECT) || (w_state_next == S_FLUSH);
            stall_fetch <= (w_state_next == S_WAIT_OPS);
            busy        <= (w_state_next != S_IDLE);

            if (w_accept) begin
                imm_address      <= w_b_off;
                imm_address_jump <= w_j_off;
                r_br_sel         <= w_dec_sel;
            end

            r_tmo_cnt   <= (r_state == S_WAIT_OPS) ? r_tmo_cnt + 8'd1 : 8'd0;
            r_flush_cnt <= ((r_state == S_REDIRECT) || (r_state == S_FLUSH))
                           ? r_flush_cnt + 4'd1 : 4'd0;

            if (w_branch_resolved && (branch_count != c_CNT_MAX)) begin
                branch_count <= branch_count + 16'd1;
            end
            // Counted on entry to REDIRECT so it is visible with the pulse
            if ((|w_pulse_next) && (taken_count != c_CNT_MAX)) begin
                taken_count <= taken_count + 16'd1;
            end
            if (w_timeout) begin
                error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Self-checking bench for branch_resolve_unit. Directed cases plus
//            randomized instruction/operand streams; expected redirects are
//            queued at issue time and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int FLUSH_CYCLES    = 2;
    localparam int OPERAND_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        operand_valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        beq, bneq, bltz, jump;
    logic [15:0] imm_address;
    logic [31:0] imm_address_jump;
    logic        flush, stall_fetch, busy;
    logic [15:0] branch_count, taken_count;
    logic        error;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .FLUSH_CYCLES    (FLUSH_CYCLES),
        .OPERAND_TIMEOUT (OPERAND_TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .operand_valid    (operand_valid),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .beq              (beq),
        .bneq             (bneq),
        .bltz             (bltz),
        .jump             (jump),
        .imm_address      (imm_address),
        .imm_address_jump (imm_address_jump),
        .flush            (flush),
        .stall_fetch      (stall_fetch),
        .busy             (busy),
        .branch_count     (branch_count),
        .taken_count      (taken_count),
        .error            (error)
    );

    typedef struct {
        logic [3:0]  pulse;   // {beq, bneq, bltz, jump}
        logic [15:0] imm_b;
        logic [31:0] imm_j;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_branch = 0;
    int          exp_taken  = 0;
    logic        exp_error  = 1'b0;
    logic [15:0] last_b = 16'd0;
    logic [31:0] last_j = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // 0 = ignored, 1 = BEQ, 2 = BNE, 3 = BLTZ, 4 = JAL
    function automatic int classify(input logic [31:0] i);
        if (i[6:0] == 7'h6F) return 4;
        if (i[6:0] == 7'h63) begin
            case (i[14:12])
                3'd0: return 1;
                3'd1: return 2;
                3'd4: return 3;
                default: return 0;
            endcase
        end
        return 0;
    endfunction

    function automatic logic [15:0] model_b_off(input logic [31:0] i);
        int v;
        v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048
            - (i[31] ? 4096 : 0);
        return 16'(v);
    endfunction

    function automatic logic [31:0] model_j_off(input logic [31:0] i);
        int v;
        v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096
            - (i[31] ? 1048576 : 0);
        return 32'(v);
    endfunction

    function automatic bit model_taken(input int kind, input logic [31:0] a, input logic [31:0] b);
        if (kind == 1) return a == b;
        if (kind == 2) return a != b;
        if (kind == 3) return $signed(a) < 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_pulse(input int kind);
        case (kind)
            1: return 4'b1000;
            2: return 4'b0100;
            3: return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    // ---------------- monitor ----------------
    int flush_run = 0;
    always @(negedge clk) begin
        if (reset) begin
            flush_run = 0;
        end else begin
            if (beq || bneq || bltz || jump) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {beq, bneq, bltz, jump}, 4'b0000);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {beq, bneq, bltz, jump}, e.pulse);
                    check("imm_address", imm_address, e.imm_b);
                    check("imm_address_jump", imm_address_jump, e.imm_j);
                    check("flush_with_pulse", flush, 1'b1);
                end
            end
            if (flush) begin
                flush_run++;
            end else if (flush_run != 0) begin
                check("flush_length", flush_run, FLUSH_CYCLES);
                flush_run = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        if (k == 50) check("wait_idle_bound", busy, 1'b0);
    endtask

    task automatic post_check();
        check("busy_idle", busy, 1'b0);
        check("flush_idle", flush, 1'b0);
        check("stall_idle", stall_fetch, 1'b0);
        check("branch_count", branch_count, 16'(exp_branch));
        check("taken_count", taken_count, 16'(exp_taken));
        check("error", error, exp_error);
        check("held_imm_b", imm_address, last_b);
        check("held_imm_j", imm_address_jump, last_j);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                             input int delay, input bit give_ops);
        int   kind;
        exp_t e;
        kind = classify(ins);
        wait_idle();
        instr_valid   = 1'b1;
        instr         = ins;
        instr_pc      = $urandom;
        // Operands in the acceptance cycle must be ignored
        operand_valid = 1'($urandom_range(0, 1));
        rs1_data      = ~a;
        rs2_data      = b + 32'd1;
        if (kind != 0) begin
            last_b = model_b_off(ins);
            last_j = model_j_off(ins);
        end
        e.imm_b = model_b_off(ins);
        e.imm_j = model_j_off(ins);
        if (kind == 0) begin
            step();
            instr_valid   = 1'b0;
            operand_valid = 1'b0;
            check("ignored_stays_idle", busy, 1'b0);
        end else if (kind == 4) begin
            e.pulse = model_pulse(4);
            exp_q.push_back(e);
            exp_taken++;
            step();
            // Decoy instruction while busy must not be accepted
            instr_valid   = 1'($urandom_range(0, 1));
            instr         = {$urandom_range(0, 32'h01FF_FFFF), 7'h6F};
            operand_valid = 1'b0;
            check("jal_busy", busy, 1'b1);
            check("jal_no_stall", stall_fetch, 1'b0);
            step();
            instr_valid = 1'b0;
            check("jal_no_stall2", stall_fetch, 1'b0);
        end else begin
            step();
            instr_valid   = 1'($urandom_range(0, 1));
            instr         = {$urandom_range(0, 32'h01FF_FFFF), 7'h6F};
            operand_valid = 1'b0;
            for (int d = 0; d < delay; d++) begin
                check("stall_wait", stall_fetch, 1'b1);
                step();
                instr_valid = 1'b0;
            end
            if (give_ops) begin
                check("stall_wait", stall_fetch, 1'b1);
                operand_valid = 1'b1;
                rs1_data      = a;
                rs2_data      = b;
                exp_branch++;
                if (model_taken(kind, a, b)) begin
                    e.pulse = model_pulse(kind);
                    exp_q.push_back(e);
                    exp_taken++;
                end
                step();
                operand_valid = 1'b0;
                instr_valid   = 1'b0;
                if (!model_taken(kind, a, b)) check("not_taken_idle", busy, 1'b0);
            end else begin
                exp_error = 1'b1;
                check("timeout_idle", busy, 1'b0);
                check("timeout_error", error, 1'b1);
            end
        end
        wait_idle();
        post_check();
    endtask

    task automatic check_all_zero();
        check("rst_pulses", {beq, bneq, bltz, jump}, 4'b0000);
        check("rst_flush", flush, 1'b0);
        check("rst_stall", stall_fetch, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_branch_count", branch_count, 16'd0);
        check("rst_taken_count", taken_count, 16'd0);
        check("rst_error", error, 1'b0);
        check("rst_imm_b", imm_address, 16'd0);
        check("rst_imm_j", imm_address_jump, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ins, a, b;
        int          r, dly;
        bit          ops;

        reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; instr_pc = 32'd0;
        operand_valid = 1'b0; rs1_data = 32'd0; rs2_data = 32'd0;
        repeat (3) step();
        check_all_zero();
        reset = 1'b0;
        step();

        // Directed cases
        run_instr(32'h0020_8463, 32'd5, 32'd5, 0, 1'b1);          // BEQ taken, +8
        check("beq_offset", last_b, 16'h0008);
        run_instr(32'h0020_8463, 32'd5, 32'd6, 0, 1'b1);          // BEQ not taken
        run_instr(32'hFF1F_F06F, 32'd0, 32'd0, 0, 1'b1);          // JAL -16
        check("jal_offset", imm_address_jump, 32'hFFFF_FFF0);
        run_instr(32'h0020_C463, 32'h8000_0000, 32'd7, 1, 1'b1);  // BLTZ taken
        run_instr(32'h0020_C463, 32'h0000_0000, 32'd7, 2, 1'b1);  // BLTZ not taken
        run_instr(32'h0020_9463, 32'd1, 32'd2, 3, 1'b1);          // BNE taken
        run_instr(32'h0020_8463, 32'd9, 32'd9, OPERAND_TIMEOUT - 1, 1'b1); // last legal cycle
        run_instr(32'h0020_A463, 32'd0, 32'd0, 0, 1'b1);          // bad funct3
        run_instr(32'h0020_8033, 32'd0, 32'd0, 0, 1'b1);          // other opcode
        run_instr(32'h0020_8463, 32'd0, 32'd0, OPERAND_TIMEOUT, 1'b0); // timeout
        run_instr(32'hFF1F_F06F, 32'd0, 32'd0, 0, 1'b1);          // error stays sticky

        // Randomized streams
        for (int n = 0; n < 200; n++) begin
            r   = $urandom_range(0, 9);
            ins = $urandom;
            if (r < 6) begin
                ins[6:0] = 7'h63;
                case ($urandom_range(0, 2))
                    0: ins[14:12] = 3'd0;
                    1: ins[14:12] = 3'd1;
                    default: ins[14:12] = 3'd4;
                endcase
            end else if (r < 8) begin
                ins[6:0] = 7'h6F;
            end else if (r == 8) begin
                int v;
                ins[6:0]   = 7'h63;
                v          = $urandom_range(0, 4);
                ins[14:12] = 3'((v < 2) ? v + 2 : v + 3);
            end else begin
                ins[6:0] = 7'($urandom_range(0, 127));
                if (ins[6:0] == 7'h63 || ins[6:0] == 7'h6F) ins[6:0] = 7'h13;
            end
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'd0;
            b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            if ($urandom_range(0, 15) == 0) begin
                ops = 1'b0;
                dly = OPERAND_TIMEOUT;
            end else begin
                ops = 1'b1;
                dly = $urandom_range(0, OPERAND_TIMEOUT - 1);
            end
            run_instr(ins, a, b, dly, ops);
        end

        // Reset while in FLUSH
        wait_idle();
        instr_valid = 1'b1;
        instr       = 32'hFF1F_F06F;
        begin
            exp_t e;
            e.pulse = 4'b0001;
            e.imm_b = model_b_off(32'hFF1F_F06F);
            e.imm_j = model_j_off(32'hFF1F_F06F);
            exp_q.push_back(e);
        end
        step();             // now in REDIRECT
        instr_valid = 1'b0;
        step();             // now in FLUSH
        check("in_flush", flush, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero();
        exp_q.delete();
        exp_branch = 0; exp_taken = 0; exp_error = 1'b0;
        last_b = 16'd0; last_j = 32'd0;
        run_instr(32'hFF1F_F06F, 32'd0, 32'd0, 0, 1'b1);          // accepted after reset

        repeat (4) step();
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
